// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: owner encoding and byte-address
// to word-index helpers used by the arbiter and its RAM addressing.
package data_memory_arbiter_pkg;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_MAU = 1'b1;

   localparam int         STARVE_CNT_WIDTH = 8;
   localparam logic [7:0] STARVE_CNT_MAX   = 8'hFF;

   // Addresses are widened to 64 bits before calling these helpers.
   localparam int IDX_CALC_WIDTH = 64;

   function automatic logic [IDX_CALC_WIDTH-1:0] word_index(
      input logic [IDX_CALC_WIDTH-1:0] address,
      input int                        depth_log2
   );
      logic [IDX_CALC_WIDTH-1:0] mask;
      mask = (64'd1 << depth_log2) - 64'd1;
      return (address >> 2) & mask;
   endfunction

   function automatic logic addr_out_of_range(
      input logic [IDX_CALC_WIDTH-1:0] address,
      input int                        depth_log2
   );
      return ((address >> 2) >> depth_log2) != 64'd0;
   endfunction

endpackage

// File: rtl/data_memory_arbiter_sp_ram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// Contents are not reset.
module sp_ram_be #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 14
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] byteen,
   input  logic [DEPTH_LOG2-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   q
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int DEPTH    = 1 << DEPTH_LOG2;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (byteen[i]) begin
               mem[address][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
      q <= mem[address];
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shared data memory for CPU and MAU over one single-port RAM: CPU-priority arbitration
// with a starvation guarantee for the MAU, 1-cycle tagged reads and an address-error pulse.
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH_LOG2   = 14,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    alive,

   input  logic                    cpu_req,
   input  logic                    cpu_wren,
   input  logic [ADDR_WIDTH-1:0]   cpu_address,
   input  logic [DATA_WIDTH/8-1:0] cpu_byteen,
   input  logic [DATA_WIDTH-1:0]   cpu_data_write,
   output logic                    cpu_gnt,
   output logic                    cpu_rvalid,
   output logic [DATA_WIDTH-1:0]   cpu_data_read,

   input  logic                    mau_req,
   input  logic                    mau_wren,
   input  logic [ADDR_WIDTH-1:0]   mau_address,
   input  logic [DATA_WIDTH/8-1:0] mau_byteen,
   input  logic [DATA_WIDTH-1:0]   mau_data_write,
   output logic                    mau_gnt,
   output logic                    mau_rvalid,
   output logic [DATA_WIDTH-1:0]   mau_data_read,

   output logic                    addr_err
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [STARVE_CNT_WIDTH-1:0] starve_cnt;
   logic                        starved;

   logic                        any_gnt;
   logic                        sel_wren;
   logic [ADDR_WIDTH-1:0]       sel_address;
   logic [BE_WIDTH-1:0]         sel_byteen;
   logic [DATA_WIDTH-1:0]       sel_data_write;
   logic [IDX_CALC_WIDTH-1:0]   sel_address_ext;
   logic                        sel_oor;

   logic                        ram_we;
   logic [DEPTH_LOG2-1:0]       ram_address;
   logic [DATA_WIDTH-1:0]       ram_q;

   logic                        owner_q;
   logic                        rd_q;
   logic                        err_q;
   logic                        oor_rd_q;
   logic [DATA_WIDTH-1:0]       rd_data;
   logic [DATA_WIDTH-1:0]       cpu_hold_q;
   logic [DATA_WIDTH-1:0]       mau_hold_q;

   assign starved = starve_cnt >= STARVE_CNT_WIDTH'(STARVE_LIMIT);

   // Grants are suppressed while reset is asserted so nothing reaches the RAM on that edge.
   always_comb begin
      cpu_gnt = 1'b0;
      mau_gnt = 1'b0;
      if (!reset) begin
         if (!alive) begin
            mau_gnt = mau_req;
         end else if (mau_req && starved) begin
            mau_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (mau_req) begin
            mau_gnt = 1'b1;
         end
      end
   end

   assign any_gnt        = cpu_gnt | mau_gnt;
   assign sel_wren       = mau_gnt ? mau_wren       : cpu_wren;
   assign sel_address    = mau_gnt ? mau_address    : cpu_address;
   assign sel_byteen     = mau_gnt ? mau_byteen     : cpu_byteen;
   assign sel_data_write = mau_gnt ? mau_data_write : cpu_data_write;

   assign sel_address_ext = IDX_CALC_WIDTH'(sel_address);
   assign sel_oor         = addr_out_of_range(sel_address_ext, DEPTH_LOG2);
   assign ram_address     = DEPTH_LOG2'(word_index(sel_address_ext, DEPTH_LOG2));
   assign ram_we          = any_gnt && sel_wren && !sel_oor;

   sp_ram_be #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .byteen  (sel_byteen),
      .address (ram_address),
      .wdata   (sel_data_write),
      .q       (ram_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!alive || mau_gnt) begin
         starve_cnt <= '0;
      end else if (mau_req && starve_cnt != STARVE_CNT_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q  <= OWNER_CPU;
         rd_q     <= 1'b0;
         err_q    <= 1'b0;
         oor_rd_q <= 1'b0;
      end else begin
         rd_q     <= any_gnt && !sel_wren;
         err_q    <= any_gnt && sel_oor;
         oor_rd_q <= any_gnt && !sel_wren && sel_oor;
         if (any_gnt) begin
            owner_q <= mau_gnt ? OWNER_MAU : OWNER_CPU;
         end
      end
   end

   // Out-of-range reads still complete, but with zero data instead of the aliased word.
   assign rd_data    = oor_rd_q ? '0 : ram_q;
   assign cpu_rvalid = rd_q && (owner_q == OWNER_CPU);
   assign mau_rvalid = rd_q && (owner_q == OWNER_MAU);
   assign addr_err   = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_hold_q <= '0;
         mau_hold_q <= '0;
      end else begin
         if (cpu_rvalid) cpu_hold_q <= rd_data;
         if (mau_rvalid) mau_hold_q <= rd_data;
      end
   end

   assign cpu_data_read = cpu_rvalid ? rd_data : cpu_hold_q;
   assign mau_data_read = mau_rvalid ? rd_data : mau_hold_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: a vector table drives one cycle per row; expected
// read responses are queued at grant time and compared when the DUT responds.
module tb_data_memory_arbiter;

   logic        clk;
   logic        reset;
   logic        alive;
   logic        cpu_req, cpu_wren;
   logic [31:0] cpu_address, cpu_data_write;
   logic [3:0]  cpu_byteen;
   logic        cpu_gnt, cpu_rvalid;
   logic [31:0] cpu_data_read;
   logic        mau_req, mau_wren;
   logic [31:0] mau_address, mau_data_write;
   logic [3:0]  mau_byteen;
   logic        mau_gnt, mau_rvalid;
   logic [31:0] mau_data_read;
   logic        addr_err;

   data_memory_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .alive          (alive),
      .cpu_req        (cpu_req),
      .cpu_wren       (cpu_wren),
      .cpu_address    (cpu_address),
      .cpu_byteen     (cpu_byteen),
      .cpu_data_write (cpu_data_write),
      .cpu_gnt        (cpu_gnt),
      .cpu_rvalid     (cpu_rvalid),
      .cpu_data_read  (cpu_data_read),
      .mau_req        (mau_req),
      .mau_wren       (mau_wren),
      .mau_address    (mau_address),
      .mau_byteen     (mau_byteen),
      .mau_data_write (mau_data_write),
      .mau_gnt        (mau_gnt),
      .mau_rvalid     (mau_rvalid),
      .mau_data_read  (mau_data_read),
      .addr_err       (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        alive;
      logic        c_req, c_wr;
      logic [31:0] c_addr;
      logic [3:0]  c_be;
      logic [31:0] c_wd;
      logic        m_req, m_wr;
      logic [31:0] m_addr;
      logic [3:0]  m_be;
      logic [31:0] m_wd;
      logic        e_cgnt, e_mgnt;
      logic [31:0] e_data;
      logic        e_err;
   } vec_t;

   typedef struct {
      logic        crv, mrv, err;
      logic [31:0] data;
   } resp_t;

   int          total = 0;
   int          bad   = 0;
   resp_t       sb[$];
   logic [31:0] last_cpu = 32'h0;
   logic [31:0] last_mau = 32'h0;
   vec_t        vecs[35];

   function automatic vec_t idle_v();
      vec_t v;
      v.alive = 1'b1;
      v.c_req = 1'b0; v.c_wr = 1'b0; v.c_addr = 32'h0; v.c_be = 4'h0; v.c_wd = 32'h0;
      v.m_req = 1'b0; v.m_wr = 1'b0; v.m_addr = 32'h0; v.m_be = 4'h0; v.m_wd = 32'h0;
      v.e_cgnt = 1'b0; v.e_mgnt = 1'b0; v.e_data = 32'h0; v.e_err = 1'b0;
      return v;
   endfunction

   // CPU-only request; it is granted exactly when alive is high
   function automatic vec_t cpu_v(logic a, logic wr, logic [31:0] addr, logic [3:0] be,
                                  logic [31:0] wd, logic [31:0] ed, logic ee);
      vec_t v;
      v = idle_v();
      v.alive = a; v.c_req = 1'b1; v.c_wr = wr; v.c_addr = addr; v.c_be = be; v.c_wd = wd;
      v.e_cgnt = a; v.e_data = ed; v.e_err = ee;
      return v;
   endfunction

   function automatic vec_t mau_v(logic a, logic wr, logic [31:0] addr, logic [3:0] be,
                                  logic [31:0] wd, logic [31:0] ed);
      vec_t v;
      v = idle_v();
      v.alive = a; v.m_req = 1'b1; v.m_wr = wr; v.m_addr = addr; v.m_be = be; v.m_wd = wd;
      v.e_mgnt = 1'b1; v.e_data = ed;
      return v;
   endfunction

   // Both ports read: CPU @0x40 (holds 0x12345678), MAU @0x10 (holds 0xDEADBEEF)
   function automatic vec_t both_v(logic a, logic mwin);
      vec_t v;
      v = idle_v();
      v.alive = a;
      v.c_req = 1'b1; v.c_addr = 32'h40; v.c_be = 4'hF;
      v.m_req = 1'b1; v.m_addr = 32'h10; v.m_be = 4'hF;
      v.e_cgnt = !mwin; v.e_mgnt = mwin;
      v.e_data = mwin ? 32'hDEADBEEF : 32'h12345678;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_resp(input int row);
      resp_t e;
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{crv: 1'b0, mrv: 1'b0, err: 1'b0, data: 32'h0};
      chk($sformatf("cpu_rvalid[%0d]", row), {31'h0, cpu_rvalid}, {31'h0, e.crv});
      chk($sformatf("mau_rvalid[%0d]", row), {31'h0, mau_rvalid}, {31'h0, e.mrv});
      chk($sformatf("addr_err[%0d]", row), {31'h0, addr_err}, {31'h0, e.err});
      if (e.crv) last_cpu = e.data;
      if (e.mrv) last_mau = e.data;
      chk($sformatf("cpu_data_read[%0d]", row), cpu_data_read, last_cpu);
      chk($sformatf("mau_data_read[%0d]", row), mau_data_read, last_mau);
   endtask

   task automatic apply(input vec_t v, input int row);
      resp_t r;
      alive = v.alive;
      cpu_req = v.c_req; cpu_wren = v.c_wr; cpu_address = v.c_addr;
      cpu_byteen = v.c_be; cpu_data_write = v.c_wd;
      mau_req = v.m_req; mau_wren = v.m_wr; mau_address = v.m_addr;
      mau_byteen = v.m_be; mau_data_write = v.m_wd;
      @(negedge clk);
      check_resp(row);
      chk($sformatf("cpu_gnt[%0d]", row), {31'h0, cpu_gnt}, {31'h0, v.e_cgnt});
      chk($sformatf("mau_gnt[%0d]", row), {31'h0, mau_gnt}, {31'h0, v.e_mgnt});
      r.crv  = v.e_cgnt && !v.c_wr;
      r.mrv  = v.e_mgnt && !v.m_wr;
      r.err  = v.e_err;
      r.data = v.e_data;
      sb.push_back(r);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // MAU-only load mode
      vecs[0] = mau_v(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
      vecs[0].c_req = 1'b1; vecs[0].c_addr = 32'h10;
      vecs[1] = mau_v(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF);
      vecs[2] = mau_v(1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0);
      vecs[3] = mau_v(1'b0, 1'b1, 32'h00, 4'hF, 32'hCAFEF00D, 32'h0);
      // byte enables, including the all-zero no-op
      vecs[4] = cpu_v(1'b1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0);
      vecs[5] = cpu_v(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0);
      vecs[6] = cpu_v(1'b1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
      vecs[7] = cpu_v(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0);
      // out of range: aliases onto word 0, which must stay intact
      vecs[8] = cpu_v(1'b1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0, 1'b1);
      vecs[9] = cpu_v(1'b1, 1'b1, 32'h0001_0000, 4'hF, 32'h55555555, 32'h0, 1'b1);
      vecs[10] = cpu_v(1'b1, 1'b0, 32'h00, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
      // read right after write
      vecs[11] = cpu_v(1'b1, 1'b1, 32'h40, 4'hF, 32'h12345678, 32'h0, 1'b0);
      vecs[12] = cpu_v(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h12345678, 1'b0);
      vecs[13] = mau_v(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD);
      // starvation 4:1 pattern, twice
      for (int i = 0; i < 10; i++) vecs[14+i] = both_v(1'b1, (i % 5) == 4);
      // alive drop grants the MAU in the same cycle
      vecs[24] = both_v(1'b0, 1'b1);
      // counter clears while alive=0 even without an MAU grant
      for (int i = 0; i < 3; i++) vecs[25+i] = both_v(1'b1, 1'b0);
      vecs[28] = cpu_v(1'b0, 1'b0, 32'h40, 4'hF, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) vecs[29+i] = both_v(1'b1, i == 4);
      vecs[34] = idle_v();

      reset = 1'b1;
      alive = 1'b0;
      cpu_req = 1'b0; cpu_wren = 1'b0; cpu_address = 32'h0; cpu_byteen = 4'h0; cpu_data_write = 32'h0;
      mau_req = 1'b0; mau_wren = 1'b0; mau_address = 32'h0; mau_byteen = 4'h0; mau_data_write = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
      chk("reset mau_rvalid", {31'h0, mau_rvalid}, 32'h0);
      chk("reset addr_err", {31'h0, addr_err}, 32'h0);
      chk("reset cpu_data_read", cpu_data_read, 32'h0);
      chk("reset mau_data_read", mau_data_read, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 35; i++) apply(vecs[i], i);

      // reset while a CPU read is presenting, with the starve counter at 2
      apply(vecs[14], 100);
      apply(vecs[14], 101);
      chk("pre-reset cpu_rvalid", {31'h0, cpu_rvalid}, 32'h1);
      reset = 1'b1;
      #1;
      chk("async cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
      chk("async cpu_data_read", cpu_data_read, 32'h0);
      chk("async mau_data_read", mau_data_read, 32'h0);
      chk("async cpu_gnt", {31'h0, cpu_gnt}, 32'h0);
      chk("async mau_gnt", {31'h0, mau_gnt}, 32'h0);
      sb.delete();
      last_cpu = 32'h0;
      last_mau = 32'h0;
      @(posedge clk);
      #1;
      chk("reset-edge cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) apply(vecs[14+i], 200 + i);
      apply(vecs[34], 205);
      apply(vecs[34], 206);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
